alu_ctrl_issue: RTL

//  Producer side of the ALU control interface: decodes a 32-bit RV32 instruction into the 3-bit

---
 rtl/alu_ctrl_pkg.sv | 45 ++++
 rtl/alu_ctrl_issue_skid_buffer2.sv | 78 +++++++
 rtl/alu_ctrl_issue.sv | 106 ++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings and the issue record for the ALU control issue stage.
package alu_ctrl_pkg;

  localparam int ISSUE_XLEN = 32;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_XOR  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_MUL  = 3'b101;
  localparam logic [2:0] ALU_ADDI = 3'b110;
  localparam logic [2:0] ALU_SRAI = 3'b111;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRA = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef struct packed {
    logic [2:0]            ctrl;
    logic                  src;
    logic [ISSUE_XLEN-1:0] imm;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic                  regwrite;
    logic                  illegal;
  } issue_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/alu_ctrl_issue_skid_buffer2.sv
// Two-entry skid buffer, generic width; 1-cycle latency when empty.
// ready_o is a register (deasserts only when both entries are held), so no combinational path from ready_i.
module skid_buffer2
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  buf_state_t       state_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic             ready_q;
  logic             valid_q;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = valid_i & ready_q;
  assign out_fire = valid_q & ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (in_fire) begin
            head_q  <= data_i;
            state_q <= BUF_ONE;
            valid_q <= 1'b1;
          end
        end
        BUF_ONE: begin
          // Simultaneous in/out replaces the head directly so the stream has no bubble.
          if (in_fire && out_fire) begin
            head_q <= data_i;
          end else if (in_fire) begin
            tail_q  <= data_i;
            state_q <= BUF_FULL;
            ready_q <= 1'b0;
          end else if (out_fire) begin
            state_q <= BUF_EMPTY;
            valid_q <= 1'b0;
          end
        end
        BUF_FULL: begin
          if (out_fire) begin
            head_q  <= tail_q;
            state_q <= BUF_ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= BUF_EMPTY;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign data_o  = head_q;

endmodule

// File: rtl/alu_ctrl_issue.sv
// Decodes RV32 ALU instructions into ALUCtrl/operand fields and issues them via a 2-entry skid buffer.
// Latency 1 cycle when empty; back-pressure holds the head stable and never drops or duplicates.
module alu_ctrl_issue
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SKID_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     inst_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [2:0]      ALUCtrl_o,
  output logic            ALUSrc_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic            RegWrite_o,
  output logic            illegal_o
);

  // Only the 2-entry buffer exists; any other depth refuses all input.
  localparam logic DEPTH_OK = (SKID_DEPTH == 2);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;
  issue_t     issue_d;
  issue_t     head;
  logic       buf_rdy;

  assign op = inst_i[6:0];
  assign f3 = inst_i[14:12];
  assign f7 = inst_i[31:25];

  always_comb begin
    issue_d      = '0;
    issue_d.ctrl = ALU_ADD;
    issue_d.rs1  = inst_i[19:15];
    issue_d.rs2  = inst_i[24:20];
    issue_d.rd   = inst_i[11:7];
    legal        = 1'b0;
    if (op == OP_R) begin
      legal = 1'b1;
      case ({f7, f3})
        {F7_BASE, F3_ADD}: issue_d.ctrl = ALU_ADD;
        {F7_ALT,  F3_ADD}: issue_d.ctrl = ALU_SUB;
        {F7_MUL,  F3_ADD}: issue_d.ctrl = ALU_MUL;
        {F7_BASE, F3_AND}: issue_d.ctrl = ALU_AND;
        {F7_BASE, F3_XOR}: issue_d.ctrl = ALU_XOR;
        {F7_BASE, F3_SLL}: issue_d.ctrl = ALU_SLL;
        default:           legal        = 1'b0;
      endcase
    end else if (op == OP_I) begin
      if (f3 == F3_ADD) begin
        legal        = 1'b1;
        issue_d.ctrl = ALU_ADDI;
        issue_d.src  = 1'b1;
        issue_d.imm  = {{(ISSUE_XLEN-12){inst_i[31]}}, inst_i[31:20]};
        issue_d.rs2  = 5'd0;
      end else if (f3 == F3_SRA && f7 == F7_ALT) begin
        legal        = 1'b1;
        issue_d.ctrl = ALU_SRAI;
        issue_d.src  = 1'b1;
        issue_d.imm  = {{(ISSUE_XLEN-5){1'b0}}, inst_i[24:20]};
        issue_d.rs2  = 5'd0;
      end
    end
    if (!legal) begin
      issue_d.ctrl = ALU_ADD;
      issue_d.src  = 1'b0;
      issue_d.imm  = '0;
    end
    issue_d.regwrite = legal;
    issue_d.illegal  = !legal;
  end

  skid_buffer2 #(
    .WIDTH($bits(issue_t))
  ) u_skid (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .valid_i(valid_i & DEPTH_OK),
    .ready_o(buf_rdy),
    .data_i (issue_d),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o (head)
  );

  assign ready_o    = buf_rdy & DEPTH_OK;
  assign ALUCtrl_o  = head.ctrl;
  assign ALUSrc_o   = head.src;
  assign imm_o      = XLEN'(head.imm);
  assign rs1_o      = head.rs1;
  assign rs2_o      = head.rs2;
  assign rd_o       = head.rd;
  assign RegWrite_o = head.regwrite;
  assign illegal_o  = head.illegal;

endmodule
